tnn_neuron_stdp: RTL and testbench

Parametrised, clocked temporal-coded spiking neuron with an on-chip weight bank and optional STDP learning. One gamma cycle of 2^TBITS time steps is processed per `start`. During the cycle the block integrates ramp-no-leak responses from NUM_INPUTS spike lines and reports the first step at which the body potential reaches THRESHOLD. It is the sequential successor to the combinational `neuron` and sits between the spike-time encoder and the column winner-take-all logic.

---
 rtl/tnn_neuron_stdp.sv | 166 ++++++++++++++++
 tb/tb_tnn_neuron_stdp.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tnn_neuron_stdp.sv
// Temporal spiking neuron: ramp-no-leak integration over one gamma cycle, first-crossing spike time, optional STDP weight update.
// Latency: start at c -> steps at c+1..c+2^TBITS, UPDATE at c+1+2^TBITS, out_valid/new weights at c+2+2^TBITS.
// Backpressure: none; start and w_load arriving while busy are dropped.
module tnn_neuron_stdp #(
    parameter int NUM_INPUTS = 8,
    parameter int WBITS      = 3,
    parameter int TBITS      = 3,
    parameter int THRESHOLD  = 8,
    parameter int W_INIT     = 4,
    localparam int PBITS     = $clog2(NUM_INPUTS * (2**WBITS - 1) + 1),
    localparam int IBITS     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        learn,
    input  logic [NUM_INPUTS-1:0]       spike_in,
    input  logic                        w_load,
    input  logic [IBITS-1:0]            w_idx,
    input  logic [WBITS-1:0]            w_data,
    output logic [NUM_INPUTS*WBITS-1:0] weights_out,
    output logic                        busy,
    output logic                        spike_out,
    output logic                        out_valid,
    output logic                        fired,
    output logic [TBITS-1:0]            spike_time
);

    typedef enum logic [1:0] {IDLE, RUN, UPDATE} state_t;

    state_t                               state_q, state_d;
    logic [TBITS-1:0]                     k_q, k_d;
    logic [PBITS-1:0]                     p_q, p_d;
    logic [NUM_INPUTS-1:0]                arr_q, arr_d;
    logic [NUM_INPUTS-1:0][WBITS-1:0]     r_q, r_d;
    logic [NUM_INPUTS-1:0][TBITS-1:0]     t_q, t_d;
    logic [NUM_INPUTS-1:0][WBITS-1:0]     w_q, w_d;
    logic                                 fr_run_q, fr_run_d;
    logic [TBITS-1:0]                     t_out_q, t_out_d;
    logic                                 learn_q, learn_d;
    logic                                 spike_out_q, spike_out_d;
    logic                                 out_valid_q, out_valid_d;
    logic                                 fired_q, fired_d;
    logic [TBITS-1:0]                     spike_time_q, spike_time_d;
    logic [PBITS-1:0]                     p_sum;

    // Next-state, integration, firing detection and STDP update.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        p_d          = p_q;
        arr_d        = arr_q;
        r_d          = r_q;
        t_d          = t_q;
        w_d          = w_q;
        fr_run_d     = fr_run_q;
        t_out_d      = t_out_q;
        learn_d      = learn_q;
        spike_out_d  = 1'b0;
        out_valid_d  = 1'b0;
        fired_d      = fired_q;
        spike_time_d = spike_time_q;
        p_sum        = p_q;
        case (state_q)
            IDLE: begin
                // A write alongside start lands before the first step reads it.
                if (w_load) begin
                    w_d[w_idx] = w_data;
                end
                if (start) begin
                    state_d  = RUN;
                    k_d      = '0;
                    p_d      = '0;
                    arr_d    = '0;
                    r_d      = '0;
                    t_d      = '0;
                    fr_run_d = 1'b0;
                    t_out_d  = '0;
                    learn_d  = learn;
                end
            end
            RUN: begin
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    if (spike_in[i] && !arr_q[i]) begin
                        arr_d[i] = 1'b1;
                        t_d[i]   = k_q;
                    end
                    // Each arrived input ramps by one per step until it has given w_i in total.
                    if ((arr_q[i] || spike_in[i]) && (r_q[i] < w_q[i])) begin
                        r_d[i] = r_q[i] + WBITS'(1);
                        p_sum  = p_sum + PBITS'(1);
                    end
                end
                p_d = p_sum;
                if ((32'(p_sum) >= 32'(THRESHOLD)) && !fr_run_q) begin
                    fr_run_d    = 1'b1;
                    t_out_d     = k_q;
                    spike_out_d = 1'b1;
                end
                k_d = k_q + TBITS'(1);
                if (k_q == '1) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                if (learn_q) begin
                    for (int i = 0; i < NUM_INPUTS; i++) begin
                        if (arr_q[i] && fr_run_q && (t_q[i] <= t_out_q)) begin
                            if (w_q[i] != '1) w_d[i] = w_q[i] + WBITS'(1);
                        end else if (arr_q[i] || fr_run_q) begin
                            if (w_q[i] != '0) w_d[i] = w_q[i] - WBITS'(1);
                        end
                    end
                end
                out_valid_d  = 1'b1;
                fired_d      = fr_run_q;
                spike_time_d = fr_run_q ? t_out_q : '0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; reset aborts any cycle in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            p_q          <= '0;
            arr_q        <= '0;
            r_q          <= '0;
            t_q          <= '0;
            w_q          <= {NUM_INPUTS{WBITS'(W_INIT)}};
            fr_run_q     <= 1'b0;
            t_out_q      <= '0;
            learn_q      <= 1'b0;
            spike_out_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            fired_q      <= 1'b0;
            spike_time_q <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            p_q          <= p_d;
            arr_q        <= arr_d;
            r_q          <= r_d;
            t_q          <= t_d;
            w_q          <= w_d;
            fr_run_q     <= fr_run_d;
            t_out_q      <= t_out_d;
            learn_q      <= learn_d;
            spike_out_q  <= spike_out_d;
            out_valid_q  <= out_valid_d;
            fired_q      <= fired_d;
            spike_time_q <= spike_time_d;
        end
    end

    assign weights_out = w_q;
    assign busy        = (state_q != IDLE);
    assign spike_out   = spike_out_q;
    assign out_valid   = out_valid_q;
    assign fired       = fired_q;
    assign spike_time  = spike_time_q;

endmodule

// File: tb/tb_tnn_neuron_stdp.sv
// Directed bench for tnn_neuron_stdp: reset, integration/firing timing, saturation, STDP update, busy handling.
// Latency: checks every RUN step, UPDATE and the out_valid cycle of each gamma cycle.
// Backpressure: none; stimulus is cycle-exact.
module tb_tnn_neuron_stdp;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        learn;
    logic [7:0]  spike_in;
    logic        w_load;
    logic [2:0]  w_idx;
    logic [2:0]  w_data;
    logic [23:0] weights_out;
    logic        busy;
    logic        spike_out;
    logic        out_valid;
    logic        fired;
    logic [2:0]  spike_time;

    int n_tests = 0;
    int n_fail  = 0;

    tnn_neuron_stdp dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .learn       (learn),
        .spike_in    (spike_in),
        .w_load      (w_load),
        .w_idx       (w_idx),
        .w_data      (w_data),
        .weights_out (weights_out),
        .busy        (busy),
        .spike_out   (spike_out),
        .out_valid   (out_valid),
        .fired       (fired),
        .spike_time  (spike_time)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_one(input int idx, input logic [2:0] val);
        w_load = 1'b1;
        w_idx  = 3'(idx);
        w_data = val;
        tick();
        w_load = 1'b0;
    endtask

    task automatic load_all(input logic [2:0] val);
        for (int i = 0; i < 8; i++) load_one(i, val);
    endtask

    // One full gamma cycle; sched holds the spike_in pattern of step s at bits [s*8 +: 8].
    // exp_fire is the expected firing step, or -1 for no fire.
    task automatic run_gamma(input string tag, input logic lrn, input logic [63:0] sched, input int exp_fire);
        start = 1'b1;
        learn = lrn;
        tick();
        start  = 1'b0;
        learn  = 1'b0;
        w_load = 1'b0;
        for (int s = 0; s < 8; s++) begin
            spike_in = sched[s*8 +: 8];
            chk({tag, "_busy_run"}, 64'(busy), 64'(1));
            chk({tag, "_spike_out_run"}, 64'(spike_out), 64'(exp_fire >= 0 && s == exp_fire + 1));
            chk({tag, "_out_valid_run"}, 64'(out_valid), 64'(0));
            tick();
        end
        spike_in = '0;
        chk({tag, "_busy_upd"}, 64'(busy), 64'(1));
        chk({tag, "_spike_out_upd"}, 64'(spike_out), 64'(exp_fire == 7));
        tick();
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_busy_done"}, 64'(busy), 64'(0));
        chk({tag, "_fired"}, 64'(fired), 64'(exp_fire >= 0));
        chk({tag, "_spike_time"}, 64'(spike_time), 64'(exp_fire >= 0 ? exp_fire : 0));
        tick();
        chk({tag, "_out_valid_drop"}, 64'(out_valid), 64'(0));
        chk({tag, "_fired_held"}, 64'(fired), 64'(exp_fire >= 0));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b1;
        learn    = 1'b1;
        spike_in = '0;
        w_load   = 1'b1;
        w_idx    = 3'd0;
        w_data   = 3'd7;

        // Reset held two cycles with start and w_load asserted: both ignored.
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_spike_out", 64'(spike_out), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_fired", 64'(fired), 64'(0));
        chk("rst_spike_time", 64'(spike_time), 64'(0));
        chk("rst_weights", 64'(weights_out), 64'(24'o44444444));
        rst    = 1'b0;
        start  = 1'b0;
        learn  = 1'b0;
        w_load = 1'b0;
        tick();
        chk("post_rst_busy", 64'(busy), 64'(0));
        chk("post_rst_weights", 64'(weights_out), 64'(24'o44444444));

        // A single write is visible the next cycle.
        load_one(2, 3'd6);
        chk("wload_single", 64'(weights_out), 64'(24'o44444644));

        // Weights 7, inputs 0 and 1 at step 0: P = 2,4,6,8 -> fires at step 3.
        load_all(3'd7);
        chk("load7", 64'(weights_out), 64'(24'o77777777));
        run_gamma("two_in", 1'b0, 64'h03, 3);
        chk("two_in_weights", 64'(weights_out), 64'(24'o77777777));

        // Input 0 alone with a duplicate pulse at step 2: P saturates at 7, no fire.
        run_gamma("dup", 1'b0, 64'h00_00_00_00_00_01_00_01, -1);
        chk("dup_weights", 64'(weights_out), 64'(24'o77777777));

        // Weights 4, learn: inputs 0-3 at step 0, input 4 at step 5 -> fire at step 1.
        load_all(3'd4);
        run_gamma("stdp", 1'b1, 64'h00_00_10_00_00_00_00_0F, 1);
        chk("stdp_weights", 64'(weights_out), 64'(24'o33335555));

        // Weights 7, every input at step 0: P = 8 at step 0, capture clamps at 7.
        load_all(3'd7);
        run_gamma("sat_hi", 1'b1, 64'hFF, 0);
        chk("sat_hi_weights", 64'(weights_out), 64'(24'o77777777));

        // Weights 0: nothing contributes, minus clamps at 0.
        load_all(3'd0);
        run_gamma("sat_lo", 1'b1, 64'hFF, -1);
        chk("sat_lo_weights", 64'(weights_out), 64'(24'o00000000));

        // start with w_load in IDLE: w0 becomes 7 for this cycle; w1=1 -> P = 2+k, fires at step 6.
        load_one(1, 3'd1);
        w_load = 1'b1;
        w_idx  = 3'd0;
        w_data = 3'd7;
        run_gamma("start_wload", 1'b0, 64'h03, 6);
        chk("start_wload_weights", 64'(weights_out), 64'(24'o00000017));

        // Busy handling: start and w_load during RUN dropped, reset at step 4 aborts.
        load_all(3'd2);
        start = 1'b1;
        tick();
        start    = 1'b0;
        spike_in = 8'hFF;
        tick();
        spike_in = '0;
        tick();
        start  = 1'b1;
        w_load = 1'b1;
        w_idx  = 3'd3;
        w_data = 3'd7;
        tick();
        start  = 1'b0;
        w_load = 1'b0;
        chk("busy_wload_ignored", 64'(weights_out), 64'(24'o22222222));
        chk("busy_still_run", 64'(busy), 64'(1));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_spike_out", 64'(spike_out), 64'(0));
        chk("abort_weights", 64'(weights_out), 64'(24'o44444444));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_no_out_valid", 64'(out_valid), 64'(0));
            chk("abort_idle", 64'(busy), 64'(0));
        end
        chk("abort_fired", 64'(fired), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
